// File: rtl/count_rr_scheduler.sv
// Round-robin arbiter that shares one event counter between NREQ requesters and
// sequences the run through idle, run and done, raising done after TARGET grants.
module count_rr_scheduler #(
    parameter int NREQ   = 4,
    parameter int CNT_W  = 8,
    parameter int TARGET = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      clear,
    input  logic [NREQ-1:0]           req,
    output logic [NREQ-1:0]           gnt,
    output logic                      count,
    output logic [CNT_W-1:0]          cnt_val,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   last_id
);

    // state | meaning
    // IDLE  | waiting for start, no grants
    // RUN   | arbitrating, each grant bumps cnt_val
    // DONE  | TARGET grants issued, holding until start or clear

    localparam int IDW = $clog2(NREQ);
    localparam logic [CNT_W-1:0] TGT_M1 = (TARGET > 0) ? CNT_W'(TARGET - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_last;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [IDW-1:0]   w_last_nxt;
    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_any;

    // Search starts at the pointer and wraps, so the most recent winner goes last.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_any     = 1'b0;
        if (r_state == S_RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_any && req[(int'(r_ptr) + k) % NREQ]) begin
                    w_any     = 1'b1;
                    w_gnt_idx = IDW'((int'(r_ptr) + k) % NREQ);
                end
            end
        end
        if (w_any) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_last_nxt  = r_last;
        if (clear) begin
            // A grant visible this cycle is deliberately dropped from the count.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_ptr_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_cnt_nxt   = '0;
                        w_ptr_nxt   = '0;
                        w_state_nxt = (TARGET == 0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_any) begin
                        w_cnt_nxt  = r_cnt + CNT_W'(1);
                        w_ptr_nxt  = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
                        w_last_nxt = w_gnt_idx;
                        if ((TARGET > 0) && (r_cnt == TGT_M1)) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_last  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign gnt     = w_gnt;
    assign count   = |w_gnt;
    assign cnt_val = r_cnt;
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign last_id = r_last;

endmodule
